// File: rtl/cs_carry_resolve.sv
// Multi-cycle carry-propagate resolver: turns a carry-save (sum, carry) pair into
// a binary result, one SEG-bit segment per cycle, LSB first, with a registered inter-segment carry.
module cs_carry_resolve #(
  parameter int WIDTH = 48,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_zero
);

  localparam int NSEG = WIDTH / SEG;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] carry_reg;
  logic [KW-1:0]    k_reg;
  logic             run_carry_reg;
  logic             cout_reg;
  logic             zero_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [SEG-1:0] sum_seg   [NSEG];
  logic [SEG-1:0] carry_seg [NSEG];
  logic [SEG-1:0] seg_s;
  logic [SEG-1:0] seg_c;
  logic [SEG-1:0] g_bit;
  logic [SEG-1:0] p_bit;
  logic [SEG-1:0] grp_g;
  logic [SEG-1:0] grp_p;
  logic [SEG:0]   carry_chain;
  logic [SEG-1:0] seg_res;
  logic           seg_cout;
  logic           seg_zero;

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_opseg
      assign sum_seg[gi]   = sum_reg[gi*SEG +: SEG];
      assign carry_seg[gi] = carry_reg[gi*SEG +: SEG];
    end
  endgenerate

  assign seg_s = sum_seg[k_reg];
  assign seg_c = carry_seg[k_reg];

  generate
    for (genvar gi = 0; gi < SEG; gi++) begin : g_gp
      assign g_bit[gi] = seg_s[gi] & seg_c[gi];
      assign p_bit[gi] = seg_s[gi] ^ seg_c[gi];
    end
  endgenerate

  // Kogge-Stone prefix over the segment; the running carry is folded into bit 0's
  // generate, so grp_g[i] ends up as the carry out of bit i.
  always_comb begin
    grp_g    = g_bit;
    grp_p    = p_bit;
    grp_g[0] = g_bit[0] | (p_bit[0] & run_carry_reg);
    for (int d = 1; d < SEG; d = d * 2) begin
      for (int i = SEG - 1; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
  end

  assign carry_chain = {grp_g, run_carry_reg};
  assign seg_res     = p_bit ^ carry_chain[SEG-1:0];
  assign seg_cout    = carry_chain[SEG];
  assign seg_zero    = ~|seg_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sum_reg       <= '0;
      carry_reg     <= '0;
      k_reg         <= '0;
      run_carry_reg <= 1'b0;
      cout_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sum_reg       <= in_sum;
            carry_reg     <= in_carry;
            run_carry_reg <= in_cin;
            k_reg         <= '0;
            cout_reg      <= 1'b0;
            zero_reg      <= 1'b1;
            in_ready_reg  <= 1'b0;
            state_reg     <= ADD;
          end
        end
        ADD: begin
          run_carry_reg <= seg_cout;
          zero_reg      <= zero_reg & seg_zero;
          if (k_reg == KW'(NSEG - 1)) begin
            k_reg         <= '0;
            cout_reg      <= seg_cout;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each result segment has its own register, written only in the ADD cycle that resolves it.
  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_resseg
      logic [SEG-1:0] seg_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          seg_reg <= '0;
        else if (state_reg == ADD && k_reg == KW'(gi))
          seg_reg <= seg_res;
      end
      assign out_result[gi*SEG +: SEG] = seg_reg;
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_cout  = cout_reg;
  assign out_zero  = zero_reg;

endmodule

// File: tb/tb_cs_carry_resolve.sv
// Scoreboard bench for cs_carry_resolve at two geometries (48/16 and 32/8), each with
// directed corner cases followed by randomized traffic against an arithmetic reference.
module tb_cs_carry_resolve;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit done_flag [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  generate
    for (genvar ci = 0; ci < 2; ci++) begin : g_cfg
      localparam int W    = (ci == 0) ? 48 : 32;
      localparam int S    = (ci == 0) ? 16 : 8;
      localparam int N    = W / S;
      localparam int NOPS = 3000;

      logic         rst_n;
      logic         in_valid;
      logic         in_ready;
      logic [W-1:0] in_sum;
      logic [W-1:0] in_carry;
      logic         in_cin;
      logic         out_valid;
      logic         out_ready;
      logic [W-1:0] out_result;
      logic         out_cout;
      logic         out_zero;

      logic [W:0] exp_q [$];
      bit rand_ready  = 1'b0;
      bit force_ready = 1'b1;

      cs_carry_resolve #(.WIDTH(W), .SEG(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_cout  (out_cout),
        .out_zero  (out_zero)
      );

      // Reference: plain (W+1)-bit addition; top bit is the carry out.
      function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c,
                                           input logic cin);
        logic [W:0] t;
        t = {1'b0, s} + {1'b0, c};
        t = t + {{W{1'b0}}, cin};
        return t;
      endfunction

      function automatic logic [W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
      endfunction

      task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic cin,
                          input bit push);
        @(negedge clk);
        in_sum   = s;
        in_carry = c;
        in_cin   = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check($sformatf("c%0d send_ready", ci), 64'(in_ready), 64'd1);
        if (push) exp_q.push_back(model(s, c, cin));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sum   = rnd_word();
        in_carry = rnd_word();
        in_cin   = 1'($urandom_range(0, 1));
      endtask

      task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
          @(posedge clk);
          #1;
          if (exp_q.size() == 0 && in_ready) break;
        end
        check($sformatf("c%0d drain", ci), 64'(exp_q.size()), 64'd0);
      endtask

      initial begin
        out_ready = 1'b1;
        forever begin
          @(posedge clk);
          #2;
          out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
      end

      // Monitor: every cycle a result is presented it must match the head of the queue.
      initial begin
        logic [W:0] e;
        forever begin
          @(negedge clk);
          if (rst_n && out_valid) begin
            check($sformatf("c%0d valid_expected", ci), 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q[0];
              check($sformatf("c%0d result", ci), 64'(out_result), 64'(e[W-1:0]));
              check($sformatf("c%0d cout", ci), 64'(out_cout), 64'(e[W]));
              check($sformatf("c%0d zero", ci), 64'(out_zero), 64'(e[W-1:0] == '0));
              if (out_ready) begin
                void'(exp_q.pop_front());
                $display("[TB] c%0d result=%h cout=%0d zero=%0d", ci, out_result, out_cout,
                         out_zero);
              end
            end
          end
        end
      end

      initial begin
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         cin;
        logic [W:0]   e;
        int           lat;
        int           seen;
        int           sent;
        int           guard;

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_sum   = '0;
        in_carry = '0;
        in_cin   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check($sformatf("c%0d rst_in_ready", ci), 64'(in_ready), 64'd1);
        check($sformatf("c%0d rst_out_valid", ci), 64'(out_valid), 64'd0);
        check($sformatf("c%0d rst_result", ci), 64'(out_result), 64'd0);
        check($sformatf("c%0d rst_cout", ci), 64'(out_cout), 64'd0);
        check($sformatf("c%0d rst_zero", ci), 64'(out_zero), 64'd0);
        rst_n = 1'b1;

        // Full-width carry ripple, plus latency from accept to out_valid.
        send('1, '0, 1'b1, 1'b1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) begin
            lat = i;
            break;
          end
        end
        check($sformatf("c%0d latency", ci), 64'(lat), 64'(N));
        wait_drain();

        // Carry crossing the first segment boundary.
        s = '0;
        s[S-1:0] = '1;
        c = '0;
        c[0] = 1'b1;
        send(s, c, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: result held, no accept in DONE.
        force_ready = 1'b0;
        @(posedge clk);
        s   = rnd_word();
        c   = rnd_word();
        cin = 1'($urandom_range(0, 1));
        e   = model(s, c, cin);
        send(s, c, cin, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) begin
          @(posedge clk);
          #1;
        end
        in_valid = 1'b1;
        in_sum   = rnd_word();
        in_carry = rnd_word();
        repeat (5) begin
          @(negedge clk);
          check($sformatf("c%0d stall_result", ci), 64'(out_result), 64'(e[W-1:0]));
          check($sformatf("c%0d stall_in_ready", ci), 64'(in_ready), 64'd0);
          check($sformatf("c%0d stall_valid", ci), 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        force_ready = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("c%0d no_accept_in_done", ci), 64'(in_ready), 64'd1);
        check($sformatf("c%0d valid_dropped", ci), 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        check($sformatf("c%0d bp_popped", ci), 64'(exp_q.size()), 64'd0);

        // Reset during the second ADD cycle aborts silently.
        send(W'(1), '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check($sformatf("c%0d midrst_in_ready", ci), 64'(in_ready), 64'd1);
        check($sformatf("c%0d midrst_valid", ci), 64'(out_valid), 64'd0);
        check($sformatf("c%0d midrst_result", ci), 64'(out_result), 64'd0);
        check($sformatf("c%0d midrst_cout", ci), 64'(out_cout), 64'd0);
        check($sformatf("c%0d midrst_zero", ci), 64'(out_zero), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (N + 4) begin
          @(negedge clk);
          if (out_valid) seen++;
        end
        check($sformatf("c%0d aborted_no_valid", ci), 64'(seen), 64'd0);
        check($sformatf("c%0d post_rst_ready", ci), 64'(in_ready), 64'd1);
        send(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'b1);
        wait_drain();

        // Randomized traffic with random backpressure and junk inputs while busy.
        rand_ready = 1'b1;
        sent  = 0;
        guard = 0;
        while (sent < NOPS && guard < 40000) begin
          @(negedge clk);
          guard++;
          if (in_ready) begin
            if ($urandom_range(0, 3) != 0) begin
              s   = rnd_word();
              c   = rnd_word();
              cin = 1'($urandom_range(0, 1));
              if ($urandom_range(0, 3) == 0) c = ~s;
              in_sum   = s;
              in_carry = c;
              in_cin   = cin;
              in_valid = 1'b1;
              exp_q.push_back(model(s, c, cin));
              sent++;
            end else begin
              in_valid = 1'b0;
            end
          end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_sum   = rnd_word();
            in_carry = rnd_word();
            in_cin   = 1'($urandom_range(0, 1));
          end
        end
        check($sformatf("c%0d random_sent", ci), 64'(sent), 64'(NOPS));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
        done_flag[ci] = 1'b1;
      end
    end
  endgenerate

  initial begin
    for (int i = 0; i < 95000; i++) begin
      @(posedge clk);
      if (done_flag[0] && done_flag[1]) break;
    end
    if (!(done_flag[0] && done_flag[1])) begin
      tests++;
      fails++;
      $display("FAIL timeout: done flags %0d%0d, expected 11", done_flag[0], done_flag[1]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
